// File: rtl/misr_pkg.sv
// Shared definitions for signature-register blocks: session states, the
// Galois MISR step function and reference feedback polynomials.
package misr_pkg;

    localparam int unsigned MISR_MAX_W = 64;

    localparam logic [3:0]  MISR_POLY_W4  = 4'h3;
    localparam logic [7:0]  MISR_POLY_W8  = 8'h1D;
    localparam logic [15:0] MISR_POLY_W16 = 16'h1021;
    localparam logic [31:0] MISR_POLY_W32 = 32'h04C11DB7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } misr_state_e;

    // Operands are zero-extended to MISR_MAX_W; bits at and above 'width' are cleared.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] data,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] fb;
        mask = (width >= MISR_MAX_W) ? '1
             : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
        fb   = (|(sig & (MISR_MAX_W'(1) << (width - 1)))) ? poly : '0;
        return ((sig << 1) ^ fb ^ data) & mask;
    endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register: loads SEED on load, folds in_data in with the
// Galois step on enable, otherwise holds.
module misr_core
    import misr_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] signature
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (enable) begin
            sig_d = WIDTH'(misr_step(MISR_MAX_W'(sig_q), MISR_MAX_W'(in_data),
                                     MISR_MAX_W'(POLY), WIDTH));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/misr_bist_compactor.sv
// BIST session controller around misr_core: counts response beats,
// then compares the final signature against the golden value.
module misr_bist_compactor
    import misr_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED  = 1,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pattern_count,
    input  logic [WIDTH-1:0] golden,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    misr_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] golden_q;
    logic             done_q;
    logic             pass_q;

    logic             accept_start;
    logic             beat;
    logic [WIDTH-1:0] step;

    // start is only honoured outside RUN; abort masks a coincident beat.
    assign accept_start = start && (state_q != ST_RUN);
    assign beat         = (state_q == ST_RUN) && in_valid && !abort;
    assign step         = WIDTH'(misr_step(MISR_MAX_W'(signature), MISR_MAX_W'(in_data),
                                           MISR_MAX_W'(POLY), WIDTH));

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_start),
        .enable    (beat),
        .in_data   (in_data),
        .signature (signature)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            golden_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        golden_q <= golden;
                        cnt_q    <= pattern_count;
                        if (pattern_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (SEED == golden);
                        end else begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (in_valid) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (step == golden_q);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_misr_bist_compactor.sv
// Directed bench for misr_bist_compactor with WIDTH=4, POLY=3, SEED=1, CNT_W=4.
module tb_misr_bist_compactor;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] pattern_count;
    logic [3:0] golden;
    logic       in_valid;
    logic [3:0] in_data;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] signature;

    int total;
    int bad;

    misr_bist_compactor #(
        .WIDTH (4),
        .POLY  (4'h3),
        .SEED  (4'h1),
        .CNT_W (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .pattern_count (pattern_count),
        .golden        (golden),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .signature     (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers return 1 time unit after the sampling edge.
    task automatic do_start(input logic [3:0] pc, input logic [3:0] g);
        start         = 1'b1;
        pattern_count = pc;
        golden        = g;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_beat(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (signature !== 4'h1) begin bad++; $display("FAIL reset_sig got=%h exp=1", signature); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b exp=0", pass); end
        reset = 1'b0;
        idle_cycle();
    endtask

    task automatic test_zero_response();
        logic [3:0] exp_sig [4] = '{4'h2, 4'h4, 4'h8, 4'h3};
        do_start(4'd4, 4'h3);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zr_busy_start got=%b exp=1", busy); end
        total++; if (signature !== 4'h1) begin bad++; $display("FAIL zr_seed got=%h exp=1", signature); end
        for (int i = 0; i < 4; i++) begin
            do_beat(4'h0);
            total++; if (signature !== exp_sig[i]) begin bad++; $display("FAIL zr_sig%0d got=%h exp=%h", i, signature, exp_sig[i]); end
            if (i < 3) begin
                total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL zr_mid%0d got done=%b busy=%b exp done=0 busy=1", i, done, busy); end
            end
        end
        total++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zr_end got done=%b pass=%b busy=%b exp 1 1 0", done, pass, busy); end
        do_beat(4'hF);
        total++; if (done !== 1'b1 || pass !== 1'b1 || signature !== 4'h3) begin bad++; $display("FAIL zr_sticky got done=%b pass=%b sig=%h exp 1 1 3", done, pass, signature); end
    endtask

    task automatic test_mismatch();
        do_start(4'd2, 4'h0);
        total++; if (done !== 1'b0 || pass !== 1'b0) begin bad++; $display("FAIL mm_clear got done=%b pass=%b exp 0 0", done, pass); end
        do_beat(4'hF);
        total++; if (signature !== 4'hD) begin bad++; $display("FAIL mm_sig0 got=%h exp=d", signature); end
        do_beat(4'h0);
        total++; if (signature !== 4'h9) begin bad++; $display("FAIL mm_sig1 got=%h exp=9", signature); end
        total++; if (done !== 1'b1 || pass !== 1'b0) begin bad++; $display("FAIL mm_end got done=%b pass=%b exp 1 0", done, pass); end
    endtask

    task automatic test_gaps();
        logic [3:0] exp_sig [4] = '{4'h2, 4'h4, 4'h8, 4'h3};
        do_start(4'd4, 4'h3);
        for (int i = 0; i < 4; i++) begin
            do_beat(4'h0);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    in_data = 4'hA;
                    idle_cycle();
                    total++; if (busy !== 1'b1 || signature !== exp_sig[i]) begin bad++; $display("FAIL gap%0d_%0d got busy=%b sig=%h exp busy=1 sig=%h", i, g, busy, signature, exp_sig[i]); end
                end
            end
        end
        total++; if (signature !== 4'h3 || done !== 1'b1 || pass !== 1'b1) begin bad++; $display("FAIL gap_end got sig=%h done=%b pass=%b exp 3 1 1", signature, done, pass); end
    endtask

    task automatic test_empty();
        do_start(4'd0, 4'h1);
        total++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL empty_match got done=%b pass=%b busy=%b exp 1 1 0", done, pass, busy); end
        idle_cycle();
        total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL empty_hold got busy=%b done=%b exp 0 1", busy, done); end
        do_start(4'd0, 4'h5);
        total++; if (done !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL empty_miss got done=%b pass=%b busy=%b exp 1 0 0", done, pass, busy); end
    endtask

    task automatic test_abort();
        do_start(4'd3, 4'h3);
        do_beat(4'h0);
        do_beat(4'h0);
        // start while running must neither reload nor change the count
        do_start(4'd1, 4'h0);
        total++; if (busy !== 1'b1 || signature !== 4'h4) begin bad++; $display("FAIL ab_ign_start got busy=%b sig=%h exp 1 4", busy, signature); end
        abort = 1'b1;
        do_beat(4'hF);
        abort = 1'b0;
        total++; if (busy !== 1'b0 || signature !== 4'h4 || done !== 1'b0 || pass !== 1'b0) begin bad++; $display("FAIL ab_abort got busy=%b sig=%h done=%b pass=%b exp 0 4 0 0", busy, signature, done, pass); end
        do_beat(4'hF);
        total++; if (signature !== 4'h4) begin bad++; $display("FAIL ab_idle_beat got=%h exp=4", signature); end
        do_start(4'd2, 4'h4);
        total++; if (signature !== 4'h1 || busy !== 1'b1) begin bad++; $display("FAIL ab_restart got sig=%h busy=%b exp 1 1", signature, busy); end
        do_beat(4'h0);
        do_beat(4'h0);
        total++; if (done !== 1'b1 || pass !== 1'b1) begin bad++; $display("FAIL ab_rerun got done=%b pass=%b exp 1 1", done, pass); end
        abort = 1'b1;
        idle_cycle();
        abort = 1'b0;
        total++; if (done !== 1'b1 || pass !== 1'b1) begin bad++; $display("FAIL ab_in_done got done=%b pass=%b exp 1 1", done, pass); end
    endtask

    task automatic test_async_reset();
        do_start(4'd4, 4'h3);
        do_beat(4'h0);
        in_valid = 1'b1;
        in_data  = 4'hF;
        #3;
        reset = 1'b1;
        #1;
        total++; if (signature !== 4'h1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin bad++; $display("FAIL arst_now got sig=%h busy=%b done=%b pass=%b exp 1 0 0 0", signature, busy, done, pass); end
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        do_beat(4'hF);
        do_beat(4'h5);
        total++; if (signature !== 4'h1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL arst_after got sig=%h busy=%b done=%b exp 1 0 0", signature, busy, done); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        pattern_count = 4'd0;
        golden        = 4'h0;
        in_valid      = 1'b0;
        in_data       = 4'h0;
        test_reset();
        test_zero_response();
        test_mismatch();
        test_gaps();
        test_empty();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
